wr_control: RTL

- Output-write sequencer; sits directly downstream of the read-address control stage in the systolic matrix unit.
- On a start request, generates the diagonal (skewed) write-enable wavefront that captures each column's results into the output memory array as they leave the systolic array.
- Also generates per-lane write addresses and done/busy status for the top-level controller.

---
 rtl/wr_control_if.sv | 23 ++
 rtl/wr_control.sv | 116 +++++++++++
 2 files changed

// File: rtl/wr_control_if.sv
// Handshake/status bundle between the read-address stage, the output-write
// sequencer and the top-level controller.
interface wr_control_if #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int ADDR_WIDTH   = 8
);
  logic                               active;
  logic [ADDR_WIDTH-1:0]              base_addr;
  logic [WIDTH_HEIGHT-1:0]            wr_en;
  logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] wr_addr;
  logic                               busy;
  logic                               done;

  modport master (
    output active, base_addr,
    input  wr_en, wr_addr, busy, done
  );

  modport slave (
    input  active, base_addr,
    output wr_en, wr_addr, busy, done
  );
endinterface

// File: rtl/wr_control.sv
// Output-write sequencer: on a rising start request, sweeps a skewed write-enable
// wavefront across the output memory lanes with per-lane incrementing addresses.
module wr_control #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic         clk,
  input  logic         reset,
  wr_control_if.slave  bus
);
  localparam int CW = $clog2(2 * WIDTH_HEIGHT);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t                  r_state, w_state_next;
  logic                    r_active_q;
  logic [CW-1:0]           r_cnt, w_cnt_next;
  logic [WIDTH_HEIGHT-1:0] r_wr_en, w_wr_en_next;
  logic                    r_busy, w_busy_next;
  logic                    r_done, w_done_next;
  logic                    w_start;
  logic                    w_addr_load;
  logic                    w_addr_clear;
  logic                    w_addr_advance;

  assign w_start = bus.active & ~r_active_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_active_q <= 1'b0;
      r_cnt      <= '0;
      r_wr_en    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_active_q <= bus.active;
      r_cnt      <= w_cnt_next;
      r_wr_en    <= w_wr_en_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_wr_en_next   = r_wr_en;
    w_busy_next    = r_busy;
    w_done_next    = r_done;
    w_addr_load    = 1'b0;
    w_addr_clear   = 1'b0;
    w_addr_advance = 1'b0;
    case (r_state)
      IDLE: begin
        // Starts arriving in any other state are simply dropped.
        if (w_start) begin
          w_wr_en_next = WIDTH_HEIGHT'(1);
          w_busy_next  = 1'b1;
          w_cnt_next   = '0;
          w_addr_load  = 1'b1;
          w_state_next = FILL;
        end
      end
      FILL: begin
        w_wr_en_next   = (r_wr_en << 1) | WIDTH_HEIGHT'(1);
        w_cnt_next     = r_cnt + CW'(1);
        w_addr_advance = 1'b1;
        if (r_cnt == CW'(WIDTH_HEIGHT - 2))
          w_state_next = DRAIN;
      end
      DRAIN: begin
        w_wr_en_next   = r_wr_en << 1;
        w_cnt_next     = r_cnt + CW'(1);
        w_addr_advance = 1'b1;
        if (r_cnt == CW'(2 * WIDTH_HEIGHT - 2)) begin
          w_state_next = DONE;
          w_done_next  = 1'b1;
          w_busy_next  = 1'b0;
        end
      end
      DONE: begin
        w_done_next  = 1'b0;
        w_addr_clear = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Each lane advances only on edges where its own enable was already high,
  // so the address shown alongside an enable is the one that write uses.
  generate
    for (genvar gi = 0; gi < WIDTH_HEIGHT; gi++) begin : g_lane
      logic [ADDR_WIDTH-1:0] r_addr;

      always_ff @(posedge clk) begin
        if (reset)
          r_addr <= '0;
        else if (w_addr_load)
          r_addr <= bus.base_addr;
        else if (w_addr_clear)
          r_addr <= '0;
        else if (w_addr_advance && r_wr_en[gi])
          r_addr <= r_addr + ADDR_WIDTH'(1);
      end

      assign bus.wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] = r_addr;
    end
  endgenerate

  assign bus.wr_en = r_wr_en;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
endmodule
